// File: rtl/uart_rx_if.sv
// uart_rx read-bus interface: address/strobe in, registered data and irq out.
// Also provides the bus width and register address macros if not already set.
`ifndef MEM_ADDR_BUS
`define MEM_ADDR_BUS [31:0]
`endif
`ifndef DATA_BUS
`define DATA_BUS [31:0]
`endif
`ifndef UART_RX_ADDR
`define UART_RX_ADDR 32'h0000_0010
`endif
`ifndef UART_RX_STATUS_ADDR
`define UART_RX_STATUS_ADDR 32'h0000_0014
`endif

interface uart_rx_if;
  logic `MEM_ADDR_BUS uart_r_addr_i;
  logic               uart_r_enable_i;
  logic `DATA_BUS     uart_data_o;
  logic               uart_irq_o;

  modport master (
    output uart_r_addr_i,
    output uart_r_enable_i,
    input  uart_data_o,
    input  uart_irq_o
  );

  modport slave (
    input  uart_r_addr_i,
    input  uart_r_enable_i,
    output uart_data_o,
    output uart_irq_o
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver with byte FIFO and status regs.
// Optional UART_RX_PARITY_EN adds an even parity bit and the perr flag.
`ifndef MEM_ADDR_BUS
`define MEM_ADDR_BUS [31:0]
`endif
`ifndef DATA_BUS
`define DATA_BUS [31:0]
`endif
`ifndef UART_RX_ADDR
`define UART_RX_ADDR 32'h0000_0010
`endif
`ifndef UART_RX_STATUS_ADDR
`define UART_RX_STATUS_ADDR 32'h0000_0014
`endif

module uart_rx #(
  parameter int CLK_DIV    = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus,
  input  logic     rx
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam logic [CW-1:0] TMAX = CW'(CLK_DIV - 1);
  localparam logic [OW-1:0] FULL = OW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] tcnt;
  logic          tick;
  logic [3:0]    os_cnt;
  logic [2:0]    state;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
`ifdef UART_RX_PARITY_EN
  logic          par_acc;
`endif

  logic          push;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic          empty;
  logic          ovr_set;
  logic          ferr_set;
  logic          perr_set;
  logic          rd_rx;
  logic          rd_st;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic          ovr;
  logic          ferr;
  logic          perr;
  logic [31:0]   status;
  logic [31:0]   data_q;
  logic          irq_q;

  assign tick  = (tcnt == TMAX);
  assign full  = (occ == FULL);
  assign empty = (occ == '0);
  assign rd_rx = bus.uart_r_enable_i &&
                 (bus.uart_r_addr_i == `UART_RX_ADDR);
  assign rd_st = bus.uart_r_enable_i &&
                 (bus.uart_r_addr_i == `UART_RX_STATUS_ADDR);
  assign pop     = rd_rx && !empty;
  assign push_ok = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  // two-flop synchronizer on the asynchronous serial line
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // free-running oversample clock-enable
  always_ff @(posedge clk) begin
    if (rst) tcnt <= '0;
    else if (tick) tcnt <= '0;
    else tcnt <= tcnt + 1'b1;
  end

  // frame FSM, advanced only on oversample ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      os_cnt  <= 4'd0;
      shift   <= 8'd0;
      bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
      par_acc <= 1'b0;
`endif
    end else if (tick) begin
      os_cnt <= os_cnt + 4'd1;
      unique case (state)
        S_IDLE: begin
          if (!rx_s) begin
            os_cnt <= 4'd0;
            state  <= S_START;
          end
        end
        S_START: begin
          if (os_cnt == 4'd7) begin
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              os_cnt  <= 4'd0;
              bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
              par_acc <= 1'b0;
`endif
              state   <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (os_cnt == 4'd15) begin
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
            par_acc <= par_acc ^ rx_s;
            if (bit_idx == 3'd7) state <= S_PARITY;
`else
            if (bit_idx == 3'd7) state <= S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (os_cnt == 4'd15) state <= S_STOP;
        end
`endif
        S_STOP: begin
          if (os_cnt == 4'd15) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // frame-end events: push on good stop, error flags otherwise
  always_comb begin
    push     = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    if (tick && os_cnt == 4'd15) begin
      if (state == S_STOP) begin
        push     = rx_s;
        ferr_set = !rx_s;
      end
`ifdef UART_RX_PARITY_EN
      if (state == S_PARITY) perr_set = rx_s ^ par_acc;
`endif
    end
  end

  // FIFO storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift;
  end

  // FIFO pointers and occupancy; push and pop may share a cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop) occ <= occ + 1'b1;
      else if (!push_ok && pop) occ <= occ - 1'b1;
    end
  end

  // sticky flags: a same-cycle set beats the clear-on-read
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
      perr <= 1'b0;
    end else begin
      ovr  <= ovr_set  | (ovr  & ~rd_st);
      ferr <= ferr_set | (ferr & ~rd_st);
`ifdef UART_RX_PARITY_EN
      perr <= perr_set | (perr & ~rd_st);
`else
      perr <= 1'b0;
`endif
    end
  end

  // status word assembly
  always_comb begin
    status            = 32'd0;
    status[0]         = !empty;
    status[1]         = ovr;
    status[2]         = ferr;
    status[3]         = perr;
    status[4 +: OW]   = occ;
  end

  // registered read data; unmapped or idle bus holds the last value
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= 32'd0;
    end else if (rd_rx) begin
      data_q <= empty ? 32'd0 : {24'd0, mem[rd_ptr]};
    end else if (rd_st) begin
      data_q <= status;
    end
  end

  // level interrupt, registered one cycle behind the flags
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else irq_q <= !empty | ovr | ferr | perr;
  end

  assign bus.uart_data_o = data_q;
  assign bus.uart_irq_o  = irq_q;

endmodule
